// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the CPU-bus to memory-array initiator.
// Kept separate so the array-side responder can reuse the same widths.
package mem_bus_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int BUS_ADDR_W = 16;
  localparam int PAGE_W     = 4;
  localparam int LAT_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    WR_LOAD,
    HOLD
  } mem_ctrl_state_t;

  typedef logic [1:0] burst_len_t;

  // Word addresses wrap inside the page, never carrying into the page bits.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Bus slave that turns single/burst CPU requests into array rdEn/wrEn cycles.
// Every output is a flop; the comb process computes next values for all of them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request addressed to PAGE
// RD_ISSUE | ArrRdEn high for one cycle, latency counter loaded next
// RD_WAIT  | counting down array latency, capture DataOut at terminal
// WR       | ArrWrEn high for one cycle, beat reported on BusValid
// WR_LOAD  | sample next BusWrData into ArrDataIn
// HOLD     | burst finished, wait for BusReq to drop
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [PAGE_W-1:0] PAGE   = 4'h0,
  parameter int                RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  resetH,
  input  logic                  BusReq,
  input  logic                  BusRW,
  input  logic [BUS_ADDR_W-1:0] BusAddr,
  input  logic [1:0]            BusLen,
  input  logic [DATA_W-1:0]     BusWrData,
  output logic [DATA_W-1:0]     BusRdData,
  output logic                  BusValid,
  output logic                  BusDone,
  output logic [ADDR_W-1:0]     ArrAddr,
  output logic [DATA_W-1:0]     ArrDataIn,
  input  logic [DATA_W-1:0]     ArrDataOut,
  output logic                  ArrRdEn,
  output logic                  ArrWrEn
);

  mem_ctrl_state_t state, stateNxt;

  logic [LAT_W-1:0]  latCnt, latCntNxt;
  burst_len_t        beatsLeft, beatsLeftNxt;
  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] rdDataNxt, dataInNxt;
  logic              rdEnNxt, wrEnNxt, validNxt, doneNxt;
  logic              pageHit;

  assign pageHit = (BusAddr[BUS_ADDR_W-1:ADDR_W] == PAGE);

  always_comb begin
    stateNxt     = state;
    latCntNxt    = latCnt;
    beatsLeftNxt = beatsLeft;
    addrNxt      = ArrAddr;
    rdDataNxt    = BusRdData;
    dataInNxt    = ArrDataIn;
    rdEnNxt      = 1'b0;
    wrEnNxt      = 1'b0;
    validNxt     = 1'b0;
    doneNxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (BusReq && pageHit) begin
          addrNxt      = BusAddr[ADDR_W-1:0];
          beatsLeftNxt = BusLen;
          if (BusRW) begin
            rdEnNxt  = 1'b1;
            stateNxt = RD_ISSUE;
          end else begin
            dataInNxt = BusWrData;
            wrEnNxt   = 1'b1;
            validNxt  = 1'b1;
            doneNxt   = (BusLen == 2'd0);
            stateNxt  = WR;
          end
        end
      end

      RD_ISSUE: begin
        latCntNxt = LAT_W'(RD_LAT);
        stateNxt  = RD_WAIT;
      end

      RD_WAIT: begin
        latCntNxt = latCnt - LAT_W'(1);
        // Terminal count: this edge takes the counter to zero.
        if (latCnt == LAT_W'(1)) begin
          rdDataNxt = ArrDataOut;
          validNxt  = 1'b1;
          if (beatsLeft == 2'd0) begin
            doneNxt  = 1'b1;
            stateNxt = HOLD;
          end else begin
            beatsLeftNxt = beatsLeft - 2'd1;
            addrNxt      = nextAddr(ArrAddr);
            rdEnNxt      = 1'b1;
            stateNxt     = RD_ISSUE;
          end
        end
      end

      WR: begin
        if (beatsLeft == 2'd0) begin
          stateNxt = HOLD;
        end else begin
          beatsLeftNxt = beatsLeft - 2'd1;
          addrNxt      = nextAddr(ArrAddr);
          stateNxt     = WR_LOAD;
        end
      end

      WR_LOAD: begin
        dataInNxt = BusWrData;
        wrEnNxt   = 1'b1;
        validNxt  = 1'b1;
        doneNxt   = (beatsLeft == 2'd0);
        stateNxt  = WR;
      end

      HOLD: begin
        if (!BusReq) stateNxt = IDLE;
      end

      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      state     <= IDLE;
      latCnt    <= '0;
      beatsLeft <= '0;
      ArrAddr   <= '0;
      ArrDataIn <= '0;
      BusRdData <= '0;
      ArrRdEn   <= 1'b0;
      ArrWrEn   <= 1'b0;
      BusValid  <= 1'b0;
      BusDone   <= 1'b0;
    end else begin
      state     <= stateNxt;
      latCnt    <= latCntNxt;
      beatsLeft <= beatsLeftNxt;
      ArrAddr   <= addrNxt;
      ArrDataIn <= dataInNxt;
      BusRdData <= rdDataNxt;
      ArrRdEn   <= rdEnNxt;
      ArrWrEn   <= wrEnNxt;
      BusValid  <= validNxt;
      BusDone   <= doneNxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: two instances (read latency 1 and 2),
// each backed by a behavioural array, checked against a word-level memory model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        resetH;
  logic        busReq[2];
  logic        busRW;
  logic [15:0] busAddr;
  logic [1:0]  busLen;
  logic [15:0] busWrData;
  logic [15:0] busRdData[2];
  logic        busValid[2];
  logic        busDone[2];
  logic [11:0] arrAddr[2];
  logic [15:0] arrDataIn[2];
  logic [15:0] arrDataOut[2];
  logic        arrRdEn[2];
  logic        arrWrEn[2];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.PAGE(4'h0), .RD_LAT(1)) dut0 (
    .clk(clk), .resetH(resetH), .BusReq(busReq[0]), .BusRW(busRW),
    .BusAddr(busAddr), .BusLen(busLen), .BusWrData(busWrData),
    .BusRdData(busRdData[0]), .BusValid(busValid[0]), .BusDone(busDone[0]),
    .ArrAddr(arrAddr[0]), .ArrDataIn(arrDataIn[0]), .ArrDataOut(arrDataOut[0]),
    .ArrRdEn(arrRdEn[0]), .ArrWrEn(arrWrEn[0]));

  mem_bus_ctrl #(.PAGE(4'h0), .RD_LAT(2)) dut1 (
    .clk(clk), .resetH(resetH), .BusReq(busReq[1]), .BusRW(busRW),
    .BusAddr(busAddr), .BusLen(busLen), .BusWrData(busWrData),
    .BusRdData(busRdData[1]), .BusValid(busValid[1]), .BusDone(busDone[1]),
    .ArrAddr(arrAddr[1]), .ArrDataIn(arrDataIn[1]), .ArrDataOut(arrDataOut[1]),
    .ArrRdEn(arrRdEn[1]), .ArrWrEn(arrWrEn[1]));

  // Behavioural arrays: DataOut valid RD_LAT cycles after the rdEn cycle.
  logic [15:0] arrMem[2][4096];
  logic [15:0] pipe[2][3];
  logic        memInit = 1'b0;

  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 4096; a++) arrMem[i][a] <= 16'h0000;
      memInit <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (arrWrEn[i]) arrMem[i][arrAddr[i]] <= arrDataIn[i];
        pipe[i][0] <= arrRdEn[i] ? arrMem[i][arrAddr[i]] : 16'hDEAD;
        pipe[i][1] <= pipe[i][0];
        pipe[i][2] <= pipe[i][1];
      end
    end
  end

  assign arrDataOut[0] = pipe[0][0];
  assign arrDataOut[1] = pipe[1][1];

  // Reference model and scoreboard
  typedef struct {
    int          inst;
    bit          isRead;
    logic [11:0] addr;
    logic [15:0] data;
    bit          last;
    bit          first;
  } beat_t;

  typedef struct {
    int          inst;
    logic [11:0] addr;
  } rd_t;

  beat_t       expQ[$];
  rd_t         rdQ[$];
  int          rdCycQ[$];
  logic [15:0] refMem[2][4096];
  logic [15:0] wd[4];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lastWrCyc = 0;
  int          actCnt = 0;
  int          rdEnSeen[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever an instance presents activity.
  always @(negedge clk) begin
    if (!resetH) begin
      for (int i = 0; i < 2; i++) begin
        if (arrRdEn[i] || arrWrEn[i] || busValid[i] || busDone[i]) actCnt++;
        if (arrRdEn[i] || arrWrEn[i])
          check("rd_wr_exclusive", i, 32'(arrRdEn[i] && arrWrEn[i]), 32'd0);
        if (busDone[i]) check("done_with_valid", i, 32'(busValid[i]), 32'd1);
        if (arrWrEn[i]) check("wren_with_valid", i, 32'(busValid[i]), 32'd1);
        if (arrRdEn[i]) begin
          rdEnSeen[i]++;
          if (rdQ.size() == 0) begin
            check("unexpected_rden", i, 32'd1, 32'd0);
          end else begin
            rd_t r;
            r = rdQ.pop_front();
            check("rden_inst", i, 32'(i), 32'(r.inst));
            check("rden_addr", i, 32'(arrAddr[i]), 32'(r.addr));
          end
          rdCycQ.push_back(cyc);
        end
        if (busValid[i]) begin
          if (expQ.size() == 0) begin
            check("unexpected_valid", i, 32'd1, 32'd0);
          end else begin
            beat_t e;
            e = expQ.pop_front();
            check("valid_inst", i, 32'(i), 32'(e.inst));
            check("done_flag", i, 32'(busDone[i]), 32'(e.last));
            if (e.isRead) begin
              check("rd_data", i, 32'(busRdData[i]), 32'(e.data));
              if (rdCycQ.size() == 0) check("rd_latency_missing", i, 32'd1, 32'd0);
              else check("rd_latency", i, 32'(cyc - rdCycQ.pop_front()), 32'(i + 2));
            end else begin
              check("wr_en", i, 32'(arrWrEn[i]), 32'd1);
              check("wr_addr", i, 32'(arrAddr[i]), 32'(e.addr));
              check("wr_data", i, 32'(arrDataIn[i]), 32'(e.data));
              if (!e.first) check("wr_period", i, 32'(cyc - lastWrCyc), 32'd2);
              lastWrCyc = cyc;
            end
          end
        end
      end
    end
  end

  task automatic buildExp(int inst, bit rd, logic [11:0] a, logic [1:0] len);
    for (int k = 0; k <= int'(len); k++) begin
      logic [11:0] ad;
      ad = a + 12'(k);
      if (rd) begin
        expQ.push_back('{inst: inst, isRead: 1'b1, addr: ad, data: refMem[inst][ad],
                         last: (k == int'(len)), first: (k == 0)});
        rdQ.push_back('{inst: inst, addr: ad});
      end else begin
        refMem[inst][ad] = wd[k];
        expQ.push_back('{inst: inst, isRead: 1'b0, addr: ad, data: wd[k],
                         last: (k == int'(len)), first: (k == 0)});
      end
    end
  endtask

  task automatic idleGap();
    repeat (2 + $urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic doReq(int inst, bit rd, logic [15:0] addr, logic [1:0] len);
    int  beat;
    bit  finished;
    int  actBefore;
    beat = 0;
    finished = 1'b0;
    if (addr[15:12] == 4'h0) buildExp(inst, rd, addr[11:0], len);
    busRW = rd;
    busAddr = addr;
    busLen = len;
    busWrData = wd[0];
    busReq[inst] = 1'b1;
    if (addr[15:12] != 4'h0) begin
      actBefore = actCnt;
      repeat (10) @(negedge clk);
      #1;
      check("page_miss_quiet", inst, 32'(actCnt - actBefore), 32'd0);
    end else begin
      for (int c = 0; c < 100 && !finished; c++) begin
        @(negedge clk);
        #1;
        if (busValid[inst]) begin
          if (busDone[inst]) finished = 1'b1;
          else begin
            beat++;
            busWrData = wd[beat];
          end
        end
      end
      if (!finished) check("burst_timeout", inst, 32'd0, 32'd1);
    end
    busReq[inst] = 1'b0;
    idleGap();
  endtask

  task automatic checkOutputsZero(int inst);
    check("rst_rdata", inst, 32'(busRdData[inst]), 32'd0);
    check("rst_valid", inst, 32'(busValid[inst]), 32'd0);
    check("rst_done", inst, 32'(busDone[inst]), 32'd0);
    check("rst_addr", inst, 32'(arrAddr[inst]), 32'd0);
    check("rst_datain", inst, 32'(arrDataIn[inst]), 32'd0);
    check("rst_rden", inst, 32'(arrRdEn[inst]), 32'd0);
    check("rst_wren", inst, 32'(arrWrEn[inst]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 4096; a++) refMem[i][a] = 16'h0000;
    resetH = 1'b1;
    busReq[0] = 1'b0;
    busReq[1] = 1'b0;
    busRW = 1'b0;
    busAddr = 16'h0000;
    busLen = 2'd0;
    busWrData = 16'h0000;
    for (int k = 0; k < 4; k++) wd[k] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutputsZero(0);
    checkOutputsZero(1);
    resetH = 1'b0;
    idleGap();

    // Directed: single write/read, wrapping bursts, page miss
    wd[0] = 16'hBEEF;
    doReq(0, 1'b0, 16'h0010, 2'd0);
    doReq(0, 1'b1, 16'h0010, 2'd0);
    wd[0] = 16'h0001; wd[1] = 16'h0002; wd[2] = 16'h0003; wd[3] = 16'h0004;
    doReq(1, 1'b0, 16'h0FFE, 2'd3);
    doReq(1, 1'b1, 16'h0FFE, 2'd3);
    doReq(0, 1'b1, 16'h1234, 2'd0);
    doReq(1, 1'b0, 16'h1234, 2'd2);

    // Reset during the second beat of a 4-beat read
    buildExp(1, 1'b1, 12'hFFE, 2'd3);
    base = rdEnSeen[1];
    busRW = 1'b1;
    busAddr = 16'h0FFE;
    busLen = 2'd3;
    busReq[1] = 1'b1;
    for (int c = 0; c < 100 && rdEnSeen[1] < base + 2; c++) begin
      @(negedge clk);
      #1;
    end
    check("second_rden_seen", 1, 32'(rdEnSeen[1] - base), 32'd2);
    resetH = 1'b1;
    @(posedge clk);
    #1;
    checkOutputsZero(1);
    expQ.delete();
    rdQ.delete();
    rdCycQ.delete();
    busReq[1] = 1'b0;
    @(posedge clk);
    #1;
    resetH = 1'b0;
    idleGap();
    doReq(1, 1'b1, 16'h0FFF, 2'd1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int          inst;
      bit          rd;
      logic [1:0]  len;
      logic [15:0] addr;
      inst = int'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      len  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
      else addr[11:0] = 12'($urandom_range(0, 31));
      addr[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      for (int k = 0; k < 4; k++) wd[k] = 16'($urandom);
      doReq(inst, rd, addr, len);
    end

    check("scoreboard_drained", 0, 32'(expQ.size() + rdQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
